bin_to_dna: RTL and testbench
=============================

Name: bin_to_dna

Overview:
- Encodes a 64-bit binary message into a 320-bit DNA strand of 40 ASCII nucleotides.
- Each byte becomes a 5-letter word. The write path feeds bin_to_dna and the read path decodes with dna_to_bin, so dna_to_bin(bin_to_dna(m)) == m for every m.
- Processes one byte per clock, MSB byte first, and raises finish_flag when the strand is complete.

Parameters:
- NUM_BYTES, 8: number of message bytes; the msg port is 8*NUM_BYTES bits and the dna port is 40*NUM_BYTES bits.

Ports:
- clk  in  1  system clock, rising edge.
- resetN  in  1  asynchronous active-low reset.
- start  in  1  level input; its rising edge launches an encode.
- binary_msg  in  8*NUM_BYTES  message; sampled only on the launch cycle.
- dna  out  40*NUM_BYTES  ASCII strand; byte k maps to dna[(k+1)*40-1 -: 40].
- finish_flag  out  1  high when dna is complete.
- busy  out  1  high while encoding.

Behaviour:
- Symbol map: A=0, C=1, G=2, T=3. ASCII values: A=0x41, C=0x43, G=0x47, T=0x54.
- Word layout for byte b: l0 is the top byte of the word slice, l4 the bottom.
  - l0 = sym(b[7:6])
  - l1 = sym(b[5:4])
  - l3 = sym(b[3:2])
  - l2 = chosen symbol (see Optional Feature)
  - l4 = sym((b[1:0] + l2) mod 4), i.e. the decoder recovers b[1:0] = (l4 - l2) mod 4.
- start_d: registered copy of start. Launch condition = start & !start_d while in IDLE.
- FSM states: IDLE, ENCODE, DONE.
  - IDLE: on launch, latch binary_msg into msg_r, set idx = NUM_BYTES-1, clear dna to 0, clear finish_flag, set busy=1, go to ENCODE.
  - ENCODE: write word(msg_r byte idx) into dna slice idx. If idx != 0, decrement idx and stay in ENCODE. Else go to DONE.
  - DONE: finish_flag <= 1, busy <= 0, go to IDLE.
- Latency: launch at clock edge E0. The last byte is written at E(NUM_BYTES). finish_flag rises at E(NUM_BYTES+1), i.e. edge 9 for the default.
- finish_flag and dna hold their values until the next launch.
- Launch edges while busy are ignored; there is no queueing.
- binary_msg changes after E0 have no effect on the current encode.
- Reset at any time, including mid-encode: state=IDLE, idx=0, msg_r=0, dna=0, finish_flag=0, busy=0, start_d=0.
- A start held high from before reset release does not launch; a new rising edge is required.
- Undefined FSM state goes to IDLE.

Optional Feature:
- Macro: BIN_TO_DNA_HP_AVOID_EN.
- Defined: l2 is the smallest s in 0..3 with s != l1, s != l3, and (b[1:0]+s) mod 4 != l3. Three exclusions over four values guarantee that a valid s always exists. Result: no equal adjacent letters at positions 1-2, 2-3, 3-4.
- Undefined: l2 = A (0), so l4 = sym(b[1:0]).
- Decoding is identical in both builds.

Decomposition:
- dna_pkg holds:
  - nucleotide ASCII localparams A, C, G, T
  - the 2-bit symbol typedef
  - sym2ascii function
  - NUCL_W = 8, WORD_LETTERS = 5
  - the FSM state enum
- Sub-module byte_to_pentamer: combinational, 8-bit input to 40-bit output, contains the l2 selection and the macro. bin_to_dna holds the FSM, registers and slice write.

Test Plan:
- HP_AVOID on, msg = 64'h0 -> every word is "AACAC" (0x4141434143). finish_flag rises 9 edges after launch. busy is high for edges 1..8.
- HP_AVOID on, msg = 64'hFF00FF00_1B1B1B1B -> words in order TTCTA, AACAC, TTCTA, AACAC, ACAGT, ACAGT, ACAGT, ACAGT.
- HP_AVOID off, msg = 64'h0 -> all 40 letters are A (0x41). msg = 64'hFF.. (all bytes 0xFF) -> every word is "TTATT".
- Round trip: 1000 random messages through bin_to_dna then dna_to_bin, in both builds -> decoded msg equals original. With HP_AVOID on, also check that no word has equal letters at positions 1-2, 2-3 or 3-4.
- Second start pulse at edge 4 of an encode, and binary_msg changed at edge 2 -> output equals the encode of the originally latched msg; no relaunch.
- resetN low at edge 5 mid-encode -> dna=0, finish_flag=0, busy=0 immediately. After release, start held high does not launch; a fresh rising edge produces a correct strand.

Source files
------------

// File: rtl/dna_pkg.sv
// dna_pkg: shared definitions for the binary-to-DNA encoder.
//   - nucleotide ASCII codes A, C, G, T
//   - 2-bit symbol type (A=0, C=1, G=2, T=3) and its ASCII mapping
//   - letter/word widths and the encoder FSM state enum
package dna_pkg;

    localparam int unsigned NUCL_W       = 8;
    localparam int unsigned WORD_LETTERS = 5;
    localparam int unsigned WORD_W       = NUCL_W * WORD_LETTERS;

    localparam logic [NUCL_W-1:0] A = 8'h41;
    localparam logic [NUCL_W-1:0] C = 8'h43;
    localparam logic [NUCL_W-1:0] G = 8'h47;
    localparam logic [NUCL_W-1:0] T = 8'h54;

    typedef logic [1:0] sym_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Map a 2-bit symbol to its ASCII nucleotide letter.
    function automatic logic [NUCL_W-1:0] sym2ascii(input sym_t s);
        case (s)
            2'd0:    return A;
            2'd1:    return C;
            2'd2:    return G;
            default: return T;
        endcase
    endfunction

endpackage

// File: rtl/byte_to_pentamer.sv
// byte_to_pentamer: combinational encoder of one byte into a 5-letter ASCII word.
//   data_i [7:0]  : message byte
//   word_c [39:0] : {l0,l1,l2,l3,l4}, l0 in the top byte
// l0/l1/l3 carry b[7:6]/b[5:4]/b[3:2]; l4 carries b[1:0] offset by l2, so a
// decoder recovers b[1:0] = (l4 - l2) mod 4 regardless of how l2 was chosen.
// Build option BIN_TO_DNA_HP_AVOID_EN: pick l2 to avoid equal neighbouring
// letters at positions 1-2, 2-3 and 3-4; otherwise l2 is fixed to A.
module byte_to_pentamer
    import dna_pkg::*;
(
    input  logic [7:0]        data_i,
    output logic [WORD_W-1:0] word_c
);

    sym_t l0, l1, l2, l3, l4, lo;

    always_comb begin
        l0 = sym_t'(data_i[7:6]);
        l1 = sym_t'(data_i[5:4]);
        l3 = sym_t'(data_i[3:2]);
        lo = sym_t'(data_i[1:0]);
        l2 = sym_t'(0);
`ifdef BIN_TO_DNA_HP_AVOID_EN
        // Scan downward so the last hit is the smallest legal symbol; three
        // exclusions over four values always leave at least one candidate.
        for (int s = 3; s >= 0; s--) begin
            if ((sym_t'(s) != l1) && (sym_t'(s) != l3) &&
                (sym_t'(lo + sym_t'(s)) != l3)) begin
                l2 = sym_t'(s);
            end
        end
`endif
        l4 = sym_t'(lo + l2);
        word_c = {sym2ascii(l0), sym2ascii(l1), sym2ascii(l2),
                  sym2ascii(l3), sym2ascii(l4)};
    end

endmodule

// File: rtl/bin_to_dna.sv
// bin_to_dna: encodes an 8*NUM_BYTES-bit message into a 40*NUM_BYTES-bit ASCII
// DNA strand, one byte per clock, MSB byte first.
//   clk          : system clock, rising edge
//   resetN       : asynchronous active-low reset
//   start        : rising edge launches an encode (only while idle)
//   binary_msg   : message, sampled on the launch cycle only
//   dna          : strand; byte k occupies dna[(k+1)*40-1 -: 40]
//   finish_flag  : high once the strand is complete, held until next launch
//   busy         : high while encoding
// Build option BIN_TO_DNA_HP_AVOID_EN selects the homopolymer-avoiding letter
// choice inside byte_to_pentamer; the default build uses a fixed filler.
module bin_to_dna
    import dna_pkg::*;
#(
    parameter int unsigned NUM_BYTES = 8
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   start,
    input  logic [8*NUM_BYTES-1:0] binary_msg,
    output logic [40*NUM_BYTES-1:0] dna,
    output logic                   finish_flag,
    output logic                   busy
);

    localparam int unsigned MSG_W = 8 * NUM_BYTES;
    localparam int unsigned DNA_W = WORD_W * NUM_BYTES;
    localparam int unsigned IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [MSG_W-1:0]  msg_q, msg_d;
    logic [DNA_W-1:0]  dna_q, dna_d;
    logic              finish_q, finish_d;
    logic              busy_q, busy_d;
    logic              start_q;
    logic              armed_q;
    logic              launch_c;
    logic [7:0]        byte_c;
    logic [WORD_W-1:0] word_c;

    // A start that is already high when reset releases must fall before it
    // can launch; armed_q records that start has been seen low.
    assign launch_c = start & ~start_q & armed_q;

    assign byte_c = msg_q[32'(idx_q) * 8 +: 8];

    byte_to_pentamer u_enc (
        .data_i (byte_c),
        .word_c (word_c)
    );

    // Start edge detection.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            start_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            start_q <= start;
            armed_q <= armed_q | ~start;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            msg_q    <= '0;
            dna_q    <= '0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            msg_q    <= msg_d;
            dna_q    <= dna_d;
            finish_q <= finish_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        msg_d    = msg_q;
        dna_d    = dna_q;
        finish_d = finish_q;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (launch_c) begin
                    msg_d    = binary_msg;
                    idx_d    = LAST_IDX;
                    dna_d    = '0;
                    finish_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = ENCODE;
                end
            end
            ENCODE: begin
                dna_d[32'(idx_q) * WORD_W +: WORD_W] = word_c;
                if (idx_q != '0) begin
                    idx_d = idx_q - IDX_W'(1);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                finish_d = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dna         = dna_q;
    assign finish_flag = finish_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_bin_to_dna.sv
// tb_bin_to_dna: scoreboard bench for bin_to_dna. Expected strands come from an
// arithmetic reference encoder; a monitor checks each completed strand, its
// decode back to the message, and (with BIN_TO_DNA_HP_AVOID_EN) letter spacing.
module tb_bin_to_dna;

    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          resetN;
    logic          start;
    logic [63:0]   binary_msg;
    logic [319:0]  dna;
    logic          finish_flag;
    logic          busy;

    always #5 clk = ~clk;

    bin_to_dna #(.NUM_BYTES(NB)) dut (
        .clk         (clk),
        .resetN      (resetN),
        .start       (start),
        .binary_msg  (binary_msg),
        .dna         (dna),
        .finish_flag (finish_flag),
        .busy        (busy)
    );

    typedef struct {
        logic [63:0]  msg;
        logic [319:0] exp;
    } item_t;

    item_t sb[$];
    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    function automatic logic [7:0] asc(input int s);
        case (s)
            0:       return 8'h41;
            1:       return 8'h43;
            2:       return 8'h47;
            default: return 8'h54;
        endcase
    endfunction

    function automatic int sym(input logic [7:0] a);
        case (a)
            8'h41:   return 0;
            8'h43:   return 1;
            8'h47:   return 2;
            8'h54:   return 3;
            default: return 99;
        endcase
    endfunction

    function automatic logic [39:0] enc_byte(input int b);
        int l0, l1, l2, l3, l4, lo;
        l0 = b / 64;
        l1 = (b / 16) % 4;
        l3 = (b / 4) % 4;
        lo = b % 4;
        l2 = 0;
`ifdef BIN_TO_DNA_HP_AVOID_EN
        for (int s = 0; s < 4; s++) begin
            if (s != l1 && s != l3 && ((lo + s) % 4) != l3) begin
                l2 = s;
                break;
            end
        end
`endif
        l4 = (lo + l2) % 4;
        return {asc(l0), asc(l1), asc(l2), asc(l3), asc(l4)};
    endfunction

    function automatic logic [319:0] enc_msg(input logic [63:0] m);
        logic [319:0] r;
        r = '0;
        for (int k = 0; k < NB; k++) r[k*40 +: 40] = enc_byte(int'(m[k*8 +: 8]));
        return r;
    endfunction

    function automatic logic [63:0] dec(input logic [319:0] d);
        logic [63:0] r;
        logic [39:0] w;
        int l[5];
        int v;
        r = '0;
        for (int k = 0; k < NB; k++) begin
            w = d[k*40 +: 40];
            for (int j = 0; j < 5; j++) l[j] = sym(w[(4-j)*8 +: 8]);
            v = l[0]*64 + l[1]*16 + l[3]*4 + ((l[4] - l[2] + 4) % 4);
            r[k*8 +: 8] = 8'(v);
        end
        return r;
    endfunction

`ifdef BIN_TO_DNA_HP_AVOID_EN
    function automatic logic hp_ok(input logic [319:0] d);
        logic [39:0] w;
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < NB; k++) begin
            w = d[k*40 +: 40];
            if (w[31:24] == w[23:16] || w[23:16] == w[15:8] || w[15:8] == w[7:0])
                ok = 1'b0;
        end
        return ok;
    endfunction
`endif

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [319:0] got, input logic [319:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Monitor: every rising finish_flag consumes one scoreboard entry.
    logic fin_prev = 1'b0;
    always @(negedge clk) begin
        item_t it;
        if (finish_flag && !fin_prev) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_finish got=1 want=0");
            end else begin
                it = sb.pop_front();
                check("strand", dna, it.exp);
                check("roundtrip", 320'(dec(dna)), 320'(it.msg));
`ifdef BIN_TO_DNA_HP_AVOID_EN
                check("hp_adjacent", 320'(hp_ok(dna)), 320'(1));
`endif
            end
        end
        fin_prev = finish_flag;
    end

    // ---------------- stimulus ----------------
    task automatic launch(input logic [63:0] m, input logic [319:0] e);
        item_t it;
        it.msg = m;
        it.exp = e;
        sb.push_back(it);
        binary_msg = m;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!(finish_flag && !busy) && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (n >= 30) begin
            bad++;
            $display("FAIL %s_timeout got=%0d want<30", name, n);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [319:0] e_zero, e_mix, e_ff;
    logic [63:0]  m, m2;
    item_t        dummy;

    initial begin
`ifdef BIN_TO_DNA_HP_AVOID_EN
        e_zero = {8{40'h4141434143}};
        e_mix  = {40'h5454435441, 40'h4141434143, 40'h5454435441, 40'h4141434143,
                  {4{40'h4143414754}}};
        e_ff   = {8{40'h5454435441}};
`else
        e_zero = {40{8'h41}};
        e_mix  = enc_msg(64'hFF00FF00_1B1B1B1B);
        e_ff   = {8{40'h5454415454}};
`endif
        resetN = 1'b0;
        start = 1'b0;
        binary_msg = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dna", dna, '0);
        check("reset_flags", 320'({finish_flag, busy}), '0);
        resetN = 1'b1;
        @(posedge clk);
        #1;

        // Zero message with cycle-accurate busy/finish timing.
        launch(64'h0, e_zero);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            if (k <= 8) check($sformatf("lat_e%0d", k), 320'({busy, finish_flag}), 320'(2'b10));
            else        check("lat_e9", 320'({busy, finish_flag}), 320'(2'b01));
        end
        repeat (2) @(posedge clk);
        #1;

        launch(64'hFF00FF00_1B1B1B1B, e_mix);
        wait_done("mix");
        launch(64'hFFFFFFFF_FFFFFFFF, e_ff);
        wait_done("ff");

        // Relaunch attempt at edge 4 and message change after launch.
        m = {$urandom, $urandom};
        launch(m, enc_msg(m));
        @(posedge clk);
        #1 binary_msg = ~m;
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("relaunch");
        repeat (15) @(posedge clk);
        #1;
        check("no_relaunch", 320'(busy), '0);
        check("sb_empty_relaunch", 320'(sb.size()), '0);

        // Reset mid-encode, then held start, then fresh launch.
        m = {$urandom, $urandom};
        launch(m, enc_msg(m));
        repeat (5) @(posedge clk);
        dummy = sb.pop_back();
        #1 resetN = 1'b0;
        #1;
        check("midrst_dna", dna, '0);
        check("midrst_flags", 320'({finish_flag, busy}), '0);
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("held_start", 320'({busy, finish_flag}), '0);
        start = 1'b0;
        @(posedge clk);
        #1;
        m2 = {$urandom, $urandom};
        launch(m2, enc_msg(m2));
        wait_done("post_reset");

        // Random round trips.
        for (int i = 0; i < 1000; i++) begin
            m = {$urandom, $urandom};
            launch(m, enc_msg(m));
            wait_done("rand");
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", 320'(sb.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
